// File: rtl/mem_access_wb_unit.sv
// MEM stage of the 5-stage MIPS core: big-endian byte-addressed data memory
// with word stores, word/half/byte loads, and the MEM/WB pipeline register.
module mem_access_wb_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        write_back,
  input  logic [1:0]  load_mode,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        write_back_out,
  output logic [31:0] read_data,
  output logic [31:0] address_out
);

  localparam int AW = $clog2(MEM_BYTES);

  // Power-up contents are zero; reset intentionally leaves memory untouched.
  logic [7:0]    mem_r [MEM_BYTES] = '{default: 8'h00};

  logic [AW-1:0] idx_s;
  logic [AW-1:0] wbase_s;
  logic [AW-1:0] hbase_s;
  logic [31:0]   word_s;
  logic [15:0]   half_s;
  logic [7:0]    byte_s;
  logic [31:0]   mem_out_s;

  // Address wrap and silent alignment; masking keeps MEM_BYTES == 4 legal.
  assign idx_s   = address[AW-1:0];
  assign wbase_s = idx_s & ~AW'(3);
  assign hbase_s = idx_s & ~AW'(1);

  assign word_s = {mem_r[wbase_s], mem_r[wbase_s + AW'(1)],
                   mem_r[wbase_s + AW'(2)], mem_r[wbase_s + AW'(3)]};
  assign half_s = {mem_r[hbase_s], mem_r[hbase_s + AW'(1)]};
  assign byte_s = mem_r[idx_s];

  // Load select and extension; sees pre-store data on a same-cycle write.
  always_comb begin
    mem_out_s = 32'h0000_0000;
    if (mem_read) begin
      case (load_mode)
        2'b00:   mem_out_s = word_s;
        2'b01:   mem_out_s = {{16{half_s[15]}}, half_s};
        2'b10:   mem_out_s = {{24{byte_s[7]}}, byte_s};
        2'b11:   mem_out_s = {24'h00_0000, byte_s};
        default: mem_out_s = 32'h0000_0000;
      endcase
    end else begin
      mem_out_s = 32'h0000_0000;
    end
  end

  // Big-endian word store; not gated by reset.
  always_ff @(posedge clk) begin
    if (mem_write) begin
      mem_r[wbase_s]          <= write_data[31:24];
      mem_r[wbase_s + AW'(1)] <= write_data[23:16];
      mem_r[wbase_s + AW'(2)] <= write_data[15:8];
      mem_r[wbase_s + AW'(3)] <= write_data[7:0];
    end
  end

  // MEM/WB pipeline register, loaded every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data      <= 32'h0000_0000;
      address_out    <= 32'h0000_0000;
      write_back_out <= 1'b0;
    end else begin
      read_data      <= mem_out_s;
      address_out    <= address;
      write_back_out <= write_back;
    end
  end

endmodule

// File: tb/tb_mem_access_wb_unit.sv
// Directed bench for mem_access_wb_unit: loads, stores, alignment, wrap,
// read-during-write and asynchronous reset of the MEM/WB register.
module tb_mem_access_wb_unit;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic        write_back;
  logic [1:0]  load_mode;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_back_out;
  logic [31:0] read_data;
  logic [31:0] address_out;

  int passed;
  int total;

  mem_access_wb_unit #(.MEM_BYTES(1024)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .write_back    (write_back),
    .load_mode     (load_mode),
    .address       (address),
    .write_data    (write_data),
    .write_back_out(write_back_out),
    .read_data     (read_data),
    .address_out   (address_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] mode, input logic [31:0] addr);
    mem_read  = 1'b1;
    mem_write = 1'b0;
    load_mode = mode;
    address   = addr;
    tick();
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wd);
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    address    = addr;
    write_data = wd;
    tick();
    mem_write  = 1'b0;
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    reset      = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_back = 1'b1;
    load_mode  = 2'b00;
    address    = 32'h0000_0044;
    write_data = 32'h0000_0000;

    #2;
    check("reset_wb_async",   {31'd0, write_back_out}, 32'h0000_0000);
    check("reset_addr_async", address_out,             32'h0000_0000);
    check("reset_rd_async",   read_data,               32'h0000_0000);
    tick();
    check("reset_hold_wb",    {31'd0, write_back_out}, 32'h0000_0000);
    check("reset_hold_addr",  address_out,             32'h0000_0000);
    reset = 1'b0;
    tick();
    check("post_reset_wb",    {31'd0, write_back_out}, 32'h0000_0001);
    check("post_reset_addr",  address_out,             32'h0000_0044);
    check("post_reset_rd",    read_data,               32'h0000_0000);

    write_back = 1'b0;
    store(32'h0000_0010, 32'h8081_7F02);
    check("store_no_read",    read_data,               32'h0000_0000);
    check("store_wb",         {31'd0, write_back_out}, 32'h0000_0000);

    load(2'b00, 32'h0000_0010); check("word_10",  read_data, 32'h8081_7F02);
    check("word_10_addr", address_out, 32'h0000_0010);
    load(2'b00, 32'h0000_0013); check("word_13",  read_data, 32'h8081_7F02);
    load(2'b01, 32'h0000_0010); check("half_10",  read_data, 32'hFFFF_8081);
    load(2'b01, 32'h0000_0012); check("half_12",  read_data, 32'h0000_7F02);
    load(2'b01, 32'h0000_0011); check("half_11",  read_data, 32'hFFFF_8081);
    load(2'b10, 32'h0000_0011); check("sbyte_11", read_data, 32'hFFFF_FF81);
    load(2'b11, 32'h0000_0011); check("ubyte_11", read_data, 32'h0000_0081);
    load(2'b10, 32'h0000_0012); check("sbyte_12", read_data, 32'h0000_007F);
    load(2'b11, 32'h0000_0013); check("ubyte_13", read_data, 32'h0000_0002);
    load(2'b10, 32'h0000_0010); check("sbyte_10", read_data, 32'hFFFF_FF80);

    store(32'h0000_0020, 32'h1111_1111);
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    load_mode  = 2'b00;
    address    = 32'h0000_0020;
    write_data = 32'h2222_2222;
    tick();
    mem_write  = 1'b0;
    check("rdw_old",          read_data, 32'h1111_1111);
    load(2'b00, 32'h0000_0020); check("rdw_new", read_data, 32'h2222_2222);

    mem_read = 1'b0;
    address  = 32'h0000_0020;
    tick();
    check("read_disabled",    read_data, 32'h0000_0000);

    store(32'h0000_0408, 32'hCAFE_BABE);
    load(2'b00, 32'h0000_0008); check("wrap_word", read_data, 32'hCAFE_BABE);
    check("wrap_addr_out", address_out, 32'h0000_0008);
    load(2'b11, 32'h0000_0409); check("wrap_ubyte", read_data, 32'h0000_00FE);

    write_back = 1'b1;
    load_mode  = 2'b00;
    address    = 32'h0000_0008;
    reset      = 1'b1;
    #1;
    check("midreset_rd",      read_data,               32'h0000_0000);
    check("midreset_wb",      {31'd0, write_back_out}, 32'h0000_0000);
    tick();
    check("midreset_hold",    read_data,               32'h0000_0000);
    reset = 1'b0;
    tick();
    check("after_reset_mem",  read_data,               32'hCAFE_BABE);
    check("after_reset_wb",   {31'd0, write_back_out}, 32'h0000_0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
